// File: rtl/adc_pipe_encoder_param_if.sv
// Sample-side and result-side signals of the pipelined ADC encoder.
// master drives the stage codes, slave is the encoder itself.
interface adc_pipe_encoder_param_if #(
    parameter int NUM_STAGES = 2,
    parameter int FLASH_BITS = 1,
    parameter int ERR_CNT_W  = 8
);
    localparam int N = NUM_STAGES + FLASH_BITS;

    logic                    en_i;
    logic                    valid_i;
    logic [3*NUM_STAGES-1:0] d_stage_i;
    logic [FLASH_BITS-1:0]   d_flash_i;
    logic                    clr_err_i;
    logic [N-1:0]            d_o;
    logic                    valid_o;
    logic                    err_o;
    logic [ERR_CNT_W-1:0]    err_cnt_o;

    modport master (
        output en_i, valid_i, d_stage_i, d_flash_i, clr_err_i,
        input  d_o, valid_o, err_o, err_cnt_o
    );

    modport slave (
        input  en_i, valid_i, d_stage_i, d_flash_i, clr_err_i,
        output d_o, valid_o, err_o, err_cnt_o
    );
endinterface

// File: rtl/adc_pipe_encoder_param.sv
// Pipelined ADC digital back end: aligns 1.5-bit stage codes with the flash
// code, applies redundant-sign correction and counts illegal-code samples.
module adc_pipe_encoder_param #(
    parameter int NUM_STAGES = 2,
    parameter int FLASH_BITS = 1,
    parameter int ERR_CNT_W  = 8
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    adc_pipe_encoder_param_if.slave  bus
);
    localparam int N  = NUM_STAGES + FLASH_BITS;
    localparam int NW = N + 1;

    // {illegal, value[1:0]}; illegal codes fall back to midscale
    function automatic logic [2:0] dec(input logic [2:0] code);
        case (code)
            3'b001:  dec = 3'b000;
            3'b010:  dec = 3'b001;
            3'b100:  dec = 3'b010;
            default: dec = 3'b101;
        endcase
    endfunction

    logic [NUM_STAGES-1:0][2:0] aligned;
    logic [NUM_STAGES-1:0][2:0] dcd;
    logic [NUM_STAGES:1]        vld_pipe;
    logic [NW-1:0]              sum;
    logic [N-1:0]               d_next;
    logic                       err_next;
    logic                       out_vld;

    // stage s is sampled s cycles after valid_i, so NUM_STAGES-s taps line it up with the flash
    for (genvar s = 0; s < NUM_STAGES; s++) begin : g_stage
        localparam int DEPTH = NUM_STAGES - s;
        logic [DEPTH-1:0][2:0] line;

        always_ff @(posedge clk_i) begin
            if (!reset_i) begin
                line <= '0;
            end else if (bus.en_i) begin
                line[0] <= bus.d_stage_i[3*s +: 3];
                for (int k = 1; k < DEPTH; k++) line[k] <= line[k-1];
            end
        end

        assign aligned[s] = line[DEPTH-1];
        assign dcd[s]     = dec(aligned[s]);
    end

    always_comb begin
        sum      = NW'(bus.d_flash_i);
        err_next = 1'b0;
        for (int s = 0; s < NUM_STAGES; s++) begin
            sum      = sum + (NW'(dcd[s][1:0]) << (N - 2 - s));
            err_next = err_next | dcd[s][2];
        end
    end

    // the sum cannot exceed 2^N-1; the clamp only guards against a bad parameter set
    assign d_next  = sum[N] ? '1 : sum[N-1:0];
    assign out_vld = vld_pipe[NUM_STAGES];

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            vld_pipe    <= '0;
            bus.d_o     <= '0;
            bus.valid_o <= 1'b0;
            bus.err_o   <= 1'b0;
        end else if (bus.en_i) begin
            vld_pipe[1] <= bus.valid_i;
            for (int k = 2; k <= NUM_STAGES; k++) vld_pipe[k] <= vld_pipe[k-1];
            bus.valid_o <= out_vld;
            if (out_vld) begin
                bus.d_o   <= d_next;
                bus.err_o <= err_next;
            end
        end else begin
            bus.valid_o <= 1'b0;
        end
    end

    // clear beats a simultaneous increment; count sticks at all-ones
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            bus.err_cnt_o <= '0;
        end else if (bus.clr_err_i) begin
            bus.err_cnt_o <= '0;
        end else if (bus.en_i && out_vld && err_next && !(&bus.err_cnt_o)) begin
            bus.err_cnt_o <= bus.err_cnt_o + ERR_CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_adc_pipe_encoder_param.sv
// Scoreboard bench for adc_pipe_encoder_param at NUM_STAGES=2, FLASH_BITS=1.
module tb_adc_pipe_encoder_param;
    logic clk_i   = 1'b0;
    logic reset_i = 1'b0;
    always #5 clk_i = ~clk_i;

    adc_pipe_encoder_param_if #(.NUM_STAGES(2), .FLASH_BITS(1), .ERR_CNT_W(8)) bus ();

    adc_pipe_encoder_param #(.NUM_STAGES(2), .FLASH_BITS(1), .ERR_CNT_W(8)) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .bus     (bus)
    );

    typedef struct {
        logic [2:0] d;
        logic       err;
        int         due;
    } exp_t;

    exp_t       sb[$];
    int         n_chk    = 0;
    int         n_err    = 0;
    int         adv_cnt  = 0;
    logic       rst_prev = 1'b0;
    logic       en_prev  = 1'b0;
    logic       clr_prev = 1'b0;
    logic [2:0] exp_d    = '0;
    logic       exp_e    = 1'b0;
    int         exp_cnt  = 0;
    logic [2:0] p_s1     = 3'b001;
    logic       p_fa     = 1'b0;
    logic       p_fb     = 1'b0;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int val(input logic [2:0] c);
        case (c)
            3'b001:  return 0;
            3'b010:  return 1;
            3'b100:  return 2;
            default: return 1;
        endcase
    endfunction

    function automatic logic bad(input logic [2:0] c);
        return !(c == 3'b001 || c == 3'b010 || c == 3'b100);
    endfunction

    function automatic logic [2:0] rnd_code();
        if ($urandom_range(0, 3) == 0) return 3'($urandom_range(0, 7));
        return 3'(1 << $urandom_range(0, 2));
    endfunction

    // one cycle of stimulus; each sample's stage-1 and flash codes follow it 1 and 2 cycles later
    task automatic adv(input logic v, input logic [2:0] s0, input logic [2:0] s1, input logic fl,
                       input logic e = 1'b1, input logic clr = 1'b0);
        exp_t x;
        int   t;
        @(negedge clk_i);
        bus.en_i      = e;
        bus.clr_err_i = clr;
        if (e) begin
            bus.valid_i   = v;
            bus.d_stage_i = {p_s1, s0};
            bus.d_flash_i = p_fb;
            if (v) begin
                t     = 2 * val(s0) + val(s1) + int'(fl);
                x.d   = 3'((t > 7) ? 7 : t);
                x.err = bad(s0) | bad(s1);
                x.due = adv_cnt + 3;
                sb.push_back(x);
            end
            p_fb = p_fa;
            p_fa = fl;
            p_s1 = s1;
        end else begin
            bus.valid_i   = 1'($urandom_range(0, 1));
            bus.d_stage_i = 6'($urandom_range(0, 63));
            bus.d_flash_i = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic idle(input logic clr = 1'b0);
        adv(1'b0, rnd_code(), rnd_code(), 1'($urandom_range(0, 1)), 1'b1, clr);
    endtask

    task automatic stall();
        adv(1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk_i);
        reset_i       = 1'b0;
        bus.en_i      = 1'b0;
        bus.valid_i   = 1'b1;
        bus.clr_err_i = 1'b0;
        repeat (n) @(negedge clk_i);
        reset_i     = 1'b1;
        bus.en_i    = 1'b1;
        bus.valid_i = 1'b0;
        p_s1 = 3'b001;
        p_fa = 1'b0;
        p_fb = 1'b0;
    endtask

    always @(posedge clk_i) begin
        rst_prev = reset_i;
        en_prev  = bus.en_i;
        clr_prev = bus.clr_err_i;
        if (reset_i && bus.en_i) adv_cnt++;
    end

    always @(negedge clk_i) begin
        logic expv;
        exp_t e;
        expv = 1'b0;
        if (!rst_prev) begin
            sb.delete();
            exp_d   = '0;
            exp_e   = 1'b0;
            exp_cnt = 0;
        end else begin
            expv = en_prev && (sb.size() > 0) && (sb[0].due == adv_cnt);
            if (expv) begin
                e     = sb.pop_front();
                exp_d = e.d;
                exp_e = e.err;
                if (e.err && exp_cnt < 255) exp_cnt++;
            end
            if (clr_prev) exp_cnt = 0;
        end
        chk("valid_o", int'(bus.valid_o), int'(expv));
        chk("d_o", int'(bus.d_o), int'(exp_d));
        chk("err_o", int'(bus.err_o), int'(exp_e));
        chk("err_cnt_o", int'(bus.err_cnt_o), exp_cnt);
    end

    initial begin
        bus.en_i      = 1'b1;
        bus.valid_i   = 1'b0;
        bus.d_stage_i = 6'b001001;
        bus.d_flash_i = 1'b0;
        bus.clr_err_i = 1'b0;
        repeat (3) @(negedge clk_i);
        reset_i = 1'b1;

        // single sample
        adv(1'b1, 3'b100, 3'b010, 1'b1);
        repeat (5) idle();
        chk("single_d", int'(bus.d_o), 6);
        chk("single_err", int'(bus.err_o), 0);

        // full scale then zero, back to back
        adv(1'b1, 3'b100, 3'b100, 1'b1);
        adv(1'b1, 3'b001, 3'b001, 1'b0);
        repeat (5) idle();
        chk("zero_d", int'(bus.d_o), 0);

        // illegal stage code
        adv(1'b1, 3'b011, 3'b001, 1'b0);
        repeat (5) idle();
        chk("illegal_d", int'(bus.d_o), 2);
        chk("illegal_err", int'(bus.err_o), 1);
        chk("illegal_cnt", int'(bus.err_cnt_o), 1);

        // stall after the stage-1 cycle
        adv(1'b1, 3'b100, 3'b010, 1'b1);
        idle();
        repeat (3) stall();
        repeat (5) idle();
        chk("stall_d", int'(bus.d_o), 6);

        // random mix of valid, stalls and clears
        repeat (80) begin
            if ($urandom_range(0, 4) == 0) stall();
            else adv(1'($urandom_range(0, 1)), rnd_code(), rnd_code(), 1'($urandom_range(0, 1)),
                     1'b1, 1'($urandom_range(0, 19) == 0));
        end
        repeat (5) idle();

        // saturation and clear-beats-increment
        idle(1'b1);
        repeat (300) adv(1'b1, 3'b000, 3'b001, 1'b0);
        repeat (5) idle();
        chk("cnt_sat", int'(bus.err_cnt_o), 255);
        adv(1'b1, 3'b011, 3'b011, 1'b1);
        idle();
        idle(1'b1);
        chk("clr_err_seen", int'(bus.err_o), 1);
        repeat (3) idle();
        chk("clr_wins", int'(bus.err_cnt_o), 0);

        // reset mid-flight discards the sample
        adv(1'b1, 3'b100, 3'b010, 1'b1);
        do_reset(1);
        repeat (5) idle();
        chk("rst_d", int'(bus.d_o), 0);
        chk("rst_cnt", int'(bus.err_cnt_o), 0);

        repeat (6) idle();
        chk("drain", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
